// File: rtl/color_sensor_emu_pkg.sv
// Shared definitions for the colour-sensor emulator: channel encoding,
// FSM state type and power-on half-period defaults.
package color_sensor_emu_pkg;

    localparam logic [1:0] CH_RED   = 2'b00;
    localparam logic [1:0] CH_BLUE  = 2'b01;
    localparam logic [1:0] CH_CLEAR = 2'b10;
    localparam logic [1:0] CH_GREEN = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LOW,
        ST_HIGH
    } state_e;

    localparam int unsigned HP_RED_DEF   = 100;
    localparam int unsigned HP_BLUE_DEF  = 110;
    localparam int unsigned HP_CLEAR_DEF = 30;
    localparam int unsigned HP_GREEN_DEF = 140;

    function automatic int unsigned default_hp(input logic [1:0] ch);
        case (ch)
            CH_RED:   return HP_RED_DEF;
            CH_BLUE:  return HP_BLUE_DEF;
            CH_CLEAR: return HP_CLEAR_DEF;
            default:  return HP_GREEN_DEF;
        endcase
    endfunction

endpackage

// File: rtl/color_sensor_emu_pulse_gen.sv
// Half-period counter for the emulator: raises toggle when the live
// half period is reached and holds the count at 1 while hp is zero.
module sensor_pulse_gen #(
    parameter int unsigned HP_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            restart,
    input  logic            run,
    input  logic [HP_W-1:0] hp,
    output logic            toggle,
    output logic            force_low
);

    logic [HP_W-1:0] cnt_q, cnt_d;

    always_comb begin
        force_low = (hp == '0);
        toggle    = run && !force_low && (cnt_q >= hp);
        cnt_d     = '0;
        if (restart) begin
            cnt_d = HP_W'(1);
        end else if (run) begin
            if (force_low || toggle) begin
                cnt_d = HP_W'(1);
            end else begin
                cnt_d = cnt_q + HP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/color_sensor_emu.sv
// Colour-sensor output emulator: per-filter square wave with a settle
// blanking window after every filter change.
module color_sensor_emu
    import color_sensor_emu_pkg::*;
#(
    parameter int unsigned HP_W          = 16,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            En,
    input  logic            Selector1,
    input  logic            Selector2,
    input  logic            CfgWe,
    input  logic [1:0]      CfgSel,
    input  logic [HP_W-1:0] CfgHalfPeriod,
    output logic            Pulse,
    output logic [15:0]     PulseCnt,
    output logic            Settling
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    state_e                 state_q, state_d;
    logic [1:0]             sel_q, sel_d, sel_in;
    logic [SW-1:0]          settle_cnt_q, settle_cnt_d;
    logic [3:0][HP_W-1:0]   hp_q, hp_d;
    logic [15:0]            pulse_cnt_q, pulse_cnt_d;
    logic                   pulse_q, pulse_d;
    logic                   settling_q, settling_d;
    logic [HP_W-1:0]        hp_act;
    logic                   pg_restart, pg_run, pg_toggle, pg_force_low;

    sensor_pulse_gen #(
        .HP_W (HP_W)
    ) u_pulse_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (pg_restart),
        .run       (pg_run),
        .hp        (hp_act),
        .toggle    (pg_toggle),
        .force_low (pg_force_low)
    );

    always_comb begin
        sel_in       = {Selector1, Selector2};
        sel_d        = sel_in;
        hp_d         = hp_q;
        if (CfgWe) begin
            hp_d[CfgSel] = CfgHalfPeriod;
        end
        hp_act       = hp_q[sel_q];
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        pg_restart   = 1'b0;
        pg_run       = 1'b0;

        // En=0 wins, then a filter change, then the normal state walk
        if (!En) begin
            state_d      = ST_IDLE;
            settle_cnt_d = '0;
        end else if (state_q != ST_IDLE && sel_in != sel_q) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = SW'(1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SW'(1);
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SW'(SETTLE_CYCLES)) begin
                        state_d      = ST_LOW;
                        settle_cnt_d = '0;
                        pg_restart   = 1'b1;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SW'(1);
                    end
                end
                ST_LOW: begin
                    pg_run = 1'b1;
                    if (pg_toggle) begin
                        state_d = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    pg_run = 1'b1;
                    if (pg_toggle || pg_force_low) begin
                        state_d = ST_LOW;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        pulse_d     = (state_d == ST_HIGH);
        settling_d  = (state_d == ST_SETTLE);
        pulse_cnt_d = pulse_cnt_q;
        if (state_q == ST_LOW && state_d == ST_HIGH) begin
            pulse_cnt_d = pulse_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            settle_cnt_q <= '0;
            pulse_cnt_q  <= '0;
            pulse_q      <= 1'b0;
            settling_q   <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                hp_q[i] <= HP_W'(default_hp(2'(i)));
            end
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            settle_cnt_q <= settle_cnt_d;
            pulse_cnt_q  <= pulse_cnt_d;
            pulse_q      <= pulse_d;
            settling_q   <= settling_d;
            hp_q         <= hp_d;
        end
    end

    assign Pulse    = pulse_q;
    assign PulseCnt = pulse_cnt_q;
    assign Settling = settling_q;

endmodule

// File: tb/tb_color_sensor_emu.sv
// Directed scoreboard bench for color_sensor_emu: expected settle lengths,
// rise latencies and periods are queued ahead and popped as measured.
module tb_color_sensor_emu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        En = 1'b0;
    logic        Selector1 = 1'b0;
    logic        Selector2 = 1'b0;
    logic        CfgWe = 1'b0;
    logic [1:0]  CfgSel = 2'b00;
    logic [15:0] CfgHalfPeriod = '0;
    logic        Pulse;
    logic [15:0] PulseCnt;
    logic        Settling;

    always #5 clk = ~clk;

    color_sensor_emu #(
        .HP_W          (16),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .En            (En),
        .Selector1     (Selector1),
        .Selector2     (Selector2),
        .CfgWe         (CfgWe),
        .CfgSel        (CfgSel),
        .CfgHalfPeriod (CfgHalfPeriod),
        .Pulse         (Pulse),
        .PulseCnt      (PulseCnt),
        .Settling      (Settling)
    );

    int    total = 0;
    int    bad   = 0;
    int    exp_q[$];
    string tag_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input int obs);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Ticks until the next 0->1 of Pulse; -1 if it never comes.
    task automatic measure_rise(output int n);
        logic prev;
        prev = Pulse;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            n++;
            if (!prev && Pulse) return;
            prev = Pulse;
        end
        n = -1;
    endtask

    // Counts samples with Settling high, starting at the current one.
    task automatic count_settle(output int n);
        n = 0;
        while (Settling && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_level(input logic lvl);
        for (int i = 0; i < 1000; i++) begin
            if (Pulse === lvl) return;
            tick();
        end
        check("wait_level_timeout", int'(Pulse), int'(lvl));
    endtask

    task automatic set_sel(input logic [1:0] s);
        Selector1 = s[1];
        Selector2 = s[0];
    endtask

    int n;
    int pc;
    int hi_seen;

    initial begin
        @(negedge clk);
        tick();
        tick();
        check("rst_pulse", int'(Pulse), 0);
        check("rst_settling", int'(Settling), 0);
        check("rst_pulsecnt", int'(PulseCnt), 0);

        // clear channel, default hp 30
        rst_n = 1'b1;
        set_sel(2'b10);
        tick();
        push("clr_settle", 4);
        push("clr_first", 30);
        push("clr_period", 60);
        push("clr_period", 60);
        push("clr_cnt", 3);
        En = 1'b1;
        tick();
        count_settle(n);    pop_check(n);
        measure_rise(n);    pop_check(n);
        measure_rise(n);    pop_check(n);
        measure_rise(n);    pop_check(n);
        pop_check(int'(PulseCnt));

        // green, then switch to red mid-HIGH
        push("grn_settle", 4);
        push("grn_first", 140);
        set_sel(2'b11);
        tick();
        count_settle(n);    pop_check(n);
        measure_rise(n);    pop_check(n);
        repeat (10) tick();
        check("grn_high", int'(Pulse), 1);
        push("red_settle", 4);
        push("red_first", 100);
        push("red_period", 200);
        set_sel(2'b00);
        tick();
        check("sel_drop_pulse", int'(Pulse), 0);
        count_settle(n);    pop_check(n);
        measure_rise(n);    pop_check(n);
        measure_rise(n);    pop_check(n);

        // hp 5 written with counter at 50 in LOW
        wait_level(1'b0);
        repeat (49) tick();
        push("hp5_period", 10);
        CfgWe = 1'b1; CfgSel = 2'b00; CfgHalfPeriod = 16'd5;
        tick();
        CfgWe = 1'b0;
        check("hp5_wr_low", int'(Pulse), 0);
        tick();
        check("hp5_toggle", int'(Pulse), 1);
        measure_rise(n);    pop_check(n);

        // hp 0 freezes output, hp 8 resumes
        CfgWe = 1'b1; CfgHalfPeriod = 16'd0;
        tick();
        CfgWe = 1'b0;
        pc = int'(PulseCnt);
        tick();
        check("hp0_low", int'(Pulse), 0);
        hi_seen = 0;
        repeat (40) begin
            tick();
            if (Pulse) hi_seen++;
        end
        check("hp0_no_pulse", hi_seen, 0);
        check("hp0_cnt_frozen", int'(PulseCnt), pc);
        push("hp8_first", 8);
        push("hp8_period", 16);
        push("hp8_period", 16);
        CfgWe = 1'b1; CfgHalfPeriod = 16'd8;
        tick();
        CfgWe = 1'b0;
        measure_rise(n);    pop_check(n);
        measure_rise(n);    pop_check(n);
        measure_rise(n);    pop_check(n);

        // one-cycle En drop during LOW
        wait_level(1'b0);
        pc = int'(PulseCnt);
        push("en_settle", 4);
        push("en_first", 8);
        En = 1'b0;
        tick();
        check("en_idle_settling", int'(Settling), 0);
        check("en_idle_pulse", int'(Pulse), 0);
        En = 1'b1;
        tick();
        count_settle(n);    pop_check(n);
        measure_rise(n);    pop_check(n);
        check("en_cnt_kept", int'(PulseCnt), (pc + 1) % 65536);

        // config write and select change on the same cycle
        push("blu_settle", 4);
        push("blu_first", 6);
        push("blu_period", 12);
        set_sel(2'b01);
        CfgWe = 1'b1; CfgSel = 2'b01; CfgHalfPeriod = 16'd6;
        tick();
        CfgWe = 1'b0;
        count_settle(n);    pop_check(n);
        measure_rise(n);    pop_check(n);
        measure_rise(n);    pop_check(n);

        // PulseCnt wrap
        force dut.pulse_cnt_q = 16'hFFFF;
        tick();
        release dut.pulse_cnt_q;
        check("wrap_preload", int'(PulseCnt), 65535);
        push("wrap_rise", 11);
        measure_rise(n);    pop_check(n);
        check("wrap_zero", int'(PulseCnt), 0);

        // reset mid-HIGH; blue must return to its default
        tick();
        tick();
        check("pre_rst_high", int'(Pulse), 1);
        rst_n = 1'b0;
        tick();
        check("rst_mid_pulse", int'(Pulse), 0);
        check("rst_mid_cnt", int'(PulseCnt), 0);
        tick();
        check("rst_mid_settling", int'(Settling), 0);
        push("dflt_settle", 4);
        push("dflt_blue_first", 110);
        rst_n = 1'b1;
        tick();
        count_settle(n);    pop_check(n);
        measure_rise(n);    pop_check(n);
        check("dflt_cnt", int'(PulseCnt), 1);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
